// File: rtl/ddr_ctrl_sched_fsm_if.sv
// Handshake bundle between the DDR scheduler FSM and the init block, RW engine and command mux.
// The scheduler takes the slave view; whatever drives its requests takes the master view.
interface ddr_ctrl_sched_fsm_if;
  logic       ini_done;
  logic       rw_req;
  logic       rw_idle;
  logic       mrs_update;
  logic [2:0] ctrl_state;
  logic       busy;
  logic       rw_proc;
  logic       act_start;
  logic       ref_cmd;
  logic       mrs_update_rdy;
  logic [3:0] ref_debt;
  logic       ref_err;

  modport slave (
    input  ini_done, rw_req, rw_idle, mrs_update,
    output ctrl_state, busy, rw_proc, act_start, ref_cmd, mrs_update_rdy, ref_debt, ref_err
  );

  modport master (
    output ini_done, rw_req, rw_idle, mrs_update,
    input  ctrl_state, busy, rw_proc, act_start, ref_cmd, mrs_update_rdy, ref_debt, ref_err
  );
endinterface

// File: rtl/ddr_ctrl_sched_fsm.sv
// DDR4 controller scheduler: sequences init, activate, read/write, refresh and MRS update,
// keeping its own tREFI timebase with bounded refresh postponement and catch-up bursts.
//
// state    | meaning
// IDLE     | out of reset, moves to INIT on the first clock
// INIT     | waiting for the init block to finish
// ACTIVATE | row activate dwell (TRC)
// RW       | RW engine owns the bus
// WAIT     | draining the RW engine before refresh/MRS
// REFRESH  | REF issued, TRFC dwell; repeats for catch-up bursts
// UPDATE   | MRS update window (TMOD)
module ddr_ctrl_sched_fsm #(
  parameter int TRC          = 36,
  parameter int TRFC         = 280,
  parameter int TREFI        = 6240,
  parameter int TMOD         = 24,
  parameter int MAX_POSTPONE = 8
) (
  input logic               CK_t,
  input logic               reset_n,
  ddr_ctrl_sched_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_ACT    = 3'd2,
    S_RW     = 3'd3,
    S_WAIT   = 3'd4,
    S_REF    = 3'd5,
    S_UPD    = 3'd6
  } state_t;

  localparam int DWELL_MAX = (TRC > TRFC) ? ((TRC > TMOD) ? TRC : TMOD)
                                          : ((TRFC > TMOD) ? TRFC : TMOD);
  localparam int DWELL_W   = $clog2(DWELL_MAX + 1);
  localparam int REFI_W    = $clog2(TREFI);

  localparam logic [DWELL_W-1:0] TRC_LAST  = DWELL_W'(TRC - 1);
  localparam logic [DWELL_W-1:0] TRFC_LAST = DWELL_W'(TRFC - 1);
  localparam logic [DWELL_W-1:0] TMOD_LAST = DWELL_W'(TMOD - 1);
  localparam logic [REFI_W-1:0]  REFI_LAST = REFI_W'(TREFI - 1);
  localparam logic [3:0]         DEBT_MAX  = 4'(MAX_POSTPONE);

  state_t              state, state_nxt;
  logic [DWELL_W-1:0]  dwell;
  logic [REFI_W-1:0]   refi_cnt;
  logic [3:0]          debt, debt_nxt;
  logic                mrs_pend;
  logic                ref_force;
  logic                ref_err_q;

  logic post_init, refi_wrap, urgent, need_ref, ref_last, ref_dec, ref_again;

  always_comb begin
    post_init = (state != S_IDLE) && (state != S_INIT);
    refi_wrap = post_init && (refi_cnt == REFI_LAST);
    urgent    = (debt == DEBT_MAX);
    need_ref  = (debt != 4'd0) && !bus.rw_req;
    ref_last  = (state == S_REF) && (dwell == TRFC_LAST);
    ref_dec   = ref_last && (debt != 4'd0);

    if (refi_wrap && !ref_dec)
      debt_nxt = urgent ? debt : debt + 4'd1;
    else if (!refi_wrap && ref_dec)
      debt_nxt = debt - 4'd1;
    else
      debt_nxt = debt;

    ref_again = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_INIT;
      S_INIT: if (bus.ini_done) state_nxt = S_ACT;
      S_ACT: begin
        if (urgent || mrs_pend)     state_nxt = S_WAIT;
        else if (dwell == TRC_LAST) state_nxt = S_RW;
      end
      S_RW: if (need_ref || urgent || mrs_pend) state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.rw_idle) begin
          if (debt != 4'd0) state_nxt = S_REF;
          else if (mrs_pend) state_nxt = S_UPD;
          else               state_nxt = S_RW;
        end
      end
      S_REF: begin
        // a burst that started forced keeps draining even with RW traffic waiting
        if (ref_last) begin
          if (debt_nxt != 4'd0 && (!bus.rw_req || urgent || ref_force)) ref_again = 1'b1;
          else if (mrs_pend) state_nxt = S_UPD;
          else               state_nxt = S_ACT;
        end
      end
      S_UPD: if (dwell == TMOD_LAST) state_nxt = S_ACT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      dwell              <= '0;
      refi_cnt           <= '0;
      debt               <= 4'd0;
      mrs_pend           <= 1'b0;
      ref_force          <= 1'b0;
      ref_err_q          <= 1'b0;
      bus.busy           <= 1'b0;
      bus.rw_proc        <= 1'b0;
      bus.act_start      <= 1'b0;
      bus.ref_cmd        <= 1'b0;
      bus.mrs_update_rdy <= 1'b0;
    end else begin
      state <= state_nxt;
      debt  <= debt_nxt;

      if (state_nxt != state || ref_again)
        dwell <= '0;
      else if (state == S_ACT || state == S_REF || state == S_UPD)
        dwell <= dwell + 1'b1;

      if (refi_wrap)      refi_cnt <= '0;
      else if (post_init) refi_cnt <= refi_cnt + 1'b1;

      if (refi_wrap && urgent) ref_err_q <= 1'b1;

      if (state_nxt == S_UPD && state != S_UPD) mrs_pend <= 1'b0;
      else if (post_init && bus.mrs_update)    mrs_pend <= 1'b1;

      ref_force <= (state_nxt == S_REF) && (ref_force || urgent);

      bus.busy           <= (state_nxt == S_REF) || (state_nxt == S_UPD);
      bus.rw_proc        <= (state_nxt == S_RW);
      bus.act_start      <= (state_nxt == S_ACT) && (state != S_ACT);
      bus.ref_cmd        <= ((state_nxt == S_REF) && (state != S_REF)) || ref_again;
      bus.mrs_update_rdy <= (state_nxt == S_UPD) && (state != S_UPD);
    end
  end

  assign bus.ctrl_state = state;
  assign bus.ref_debt   = debt;
  assign bus.ref_err    = ref_err_q;

endmodule

// File: tb/tb_ddr_ctrl_sched_fsm.sv
// Directed bench for ddr_ctrl_sched_fsm with short timing parameters:
// a vector table for the main flow plus hand sequences for reset, forced bursts and ref_err.
module tb_ddr_ctrl_sched_fsm;
  logic CK_t    = 1'b0;
  logic reset_n = 1'b0;

  ddr_ctrl_sched_fsm_if bus();

  ddr_ctrl_sched_fsm #(
    .TRC(4), .TRFC(10), .TREFI(100), .TMOD(6), .MAX_POSTPONE(8)
  ) dut (
    .CK_t   (CK_t),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 CK_t = ~CK_t;

  typedef struct {
    string name;
    logic  ini, req, idle, mrs;
    int    run;
    int    st, busy, rwp, act, refc, rdy, debt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CK_t);
      cyc++;
    end
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input string name, input logic ini, input logic req, input logic idle,
                     input logic mrs, input int run, input int st, input int busy, input int rwp,
                     input int act, input int refc, input int rdy, input int debt);
    vec_t v;
    v.name = name; v.ini = ini; v.req = req; v.idle = idle; v.mrs = mrs; v.run = run;
    v.st = st; v.busy = busy; v.rwp = rwp; v.act = act; v.refc = refc; v.rdy = rdy; v.debt = debt;
    vecs.push_back(v);
  endtask

  initial begin
    int npulse, first, prev, first8, max_debt;

    bus.ini_done = 1'b0; bus.rw_req = 1'b0; bus.rw_idle = 1'b1; bus.mrs_update = 1'b0;

    //   name             ini req idl mrs run  st bsy rwp act ref rdy debt
    add("init_entry",     0,  0,  1,  0,  1,   1, 0,  0,  0,  0,  0,  0);
    add("init_hold",      0,  0,  1,  0,  18,  1, 0,  0,  0,  0,  0,  0);
    add("act_entry",      1,  0,  1,  0,  1,   2, 0,  0,  1,  0,  0,  0);
    add("act_dwell",      1,  0,  1,  0,  3,   2, 0,  0,  0,  0,  0,  0);
    add("rw_entry",       1,  0,  1,  0,  1,   3, 0,  1,  0,  0,  0,  0);
    add("rw_pre_wrap",    1,  0,  1,  0,  95,  3, 0,  1,  0,  0,  0,  0);
    add("refi_wrap",      1,  0,  1,  0,  1,   3, 0,  1,  0,  0,  0,  1);
    add("wait_entry",     1,  0,  1,  0,  1,   4, 0,  0,  0,  0,  0,  1);
    add("ref_entry",      1,  0,  1,  0,  1,   5, 1,  0,  0,  1,  0,  1);
    add("ref_hold",       1,  0,  1,  0,  1,   5, 1,  0,  0,  0,  0,  1);
    add("ref_last",       1,  0,  1,  0,  8,   5, 1,  0,  0,  0,  0,  1);
    add("ref_to_act",     1,  0,  1,  0,  1,   2, 0,  0,  1,  0,  0,  0);
    add("act_to_rw",      1,  0,  1,  0,  4,   3, 0,  1,  0,  0,  0,  0);
    add("rw_wrap2",       1,  0,  1,  0,  84,  3, 0,  1,  0,  0,  0,  1);
    add("mrs_with_ref",   1,  0,  1,  1,  1,   4, 0,  0,  0,  0,  0,  1);
    add("ref_before_upd", 1,  0,  1,  0,  1,   5, 1,  0,  0,  1,  0,  1);
    add("ref_end",        1,  0,  1,  0,  9,   5, 1,  0,  0,  0,  0,  1);
    add("upd_entry",      1,  0,  1,  0,  1,   6, 1,  0,  0,  0,  1,  0);
    add("upd_hold",       1,  0,  1,  0,  5,   6, 1,  0,  0,  0,  0,  0);
    add("upd_to_act",     1,  0,  1,  0,  1,   2, 0,  0,  1,  0,  0,  0);
    add("act_to_rw2",     1,  0,  1,  0,  4,   3, 0,  1,  0,  0,  0,  0);
    add("rw_wrap3",       1,  0,  0,  0,  78,  3, 0,  1,  0,  0,  0,  1);
    add("wait_busy_rw",   1,  0,  0,  0,  1,   4, 0,  0,  0,  0,  0,  1);
    add("wait_hold",      1,  0,  0,  0,  49,  4, 0,  0,  0,  0,  0,  1);
    add("wait_release",   1,  0,  1,  0,  1,   5, 1,  0,  0,  1,  0,  1);

    // reset state
    step(3);
    check("rst_state", int'(bus.ctrl_state), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_rw_proc", int'(bus.rw_proc), 0);
    check("rst_ref_cmd", int'(bus.ref_cmd), 0);
    check("rst_debt", int'(bus.ref_debt), 0);
    check("rst_err", int'(bus.ref_err), 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      bus.ini_done   = vecs[i].ini;
      bus.rw_req     = vecs[i].req;
      bus.rw_idle    = vecs[i].idle;
      bus.mrs_update = vecs[i].mrs;
      step(vecs[i].run);
      check({vecs[i].name, ".state"},     int'(bus.ctrl_state),     vecs[i].st);
      check({vecs[i].name, ".busy"},      int'(bus.busy),           vecs[i].busy);
      check({vecs[i].name, ".rw_proc"},   int'(bus.rw_proc),        vecs[i].rwp);
      check({vecs[i].name, ".act_start"}, int'(bus.act_start),      vecs[i].act);
      check({vecs[i].name, ".ref_cmd"},   int'(bus.ref_cmd),        vecs[i].refc);
      check({vecs[i].name, ".mrs_rdy"},   int'(bus.mrs_update_rdy), vecs[i].rdy);
      check({vecs[i].name, ".ref_debt"},  int'(bus.ref_debt),       vecs[i].debt);
    end

    // async reset in the middle of a refresh
    step(4);
    check("mid_ref_state", int'(bus.ctrl_state), 5);
    reset_n = 1'b0;
    #1;
    check("async_rst_state", int'(bus.ctrl_state), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_debt", int'(bus.ref_debt), 0);
    step(2);
    check("rst_hold_state", int'(bus.ctrl_state), 0);
    bus.ini_done = 1'b1; bus.rw_req = 1'b1; bus.rw_idle = 1'b1; bus.mrs_update = 1'b0;
    reset_n = 1'b1;
    step(1);
    check("restart_init", int'(bus.ctrl_state), 1);
    step(1);
    check("restart_act", int'(bus.ctrl_state), 2);
    check("restart_act_start", int'(bus.act_start), 1);

    // rw_req held: postpone to MAX_POSTPONE, then a forced 8-REF burst
    npulse = 0; first = -1; prev = -1; first8 = -1; max_debt = 0;
    for (int k = 1; k <= 890; k++) begin
      step(1);
      if (bus.ref_cmd) begin
        if (npulse == 0) first = k;
        else check("burst_spacing", k - prev, 10);
        prev = k;
        npulse++;
      end
      if (int'(bus.ref_debt) > max_debt) max_debt = int'(bus.ref_debt);
      if (bus.ref_debt == 4'd8 && first8 < 0) first8 = k;
    end
    check("debt_sat_cycle", first8, 800);
    check("first_forced_ref", first, 802);
    check("burst_count", npulse, 8);
    check("debt_max", max_debt, 8);
    check("burst_debt_end", int'(bus.ref_debt), 0);
    check("burst_err", int'(bus.ref_err), 0);
    check("burst_back_rw", int'(bus.ctrl_state), 3);

    // RW engine never idles: debt saturates, next wrap raises the sticky error
    bus.rw_idle = 1'b0;
    step(809);
    check("sat_wait_state", int'(bus.ctrl_state), 4);
    check("sat_debt", int'(bus.ref_debt), 8);
    check("sat_err_before", int'(bus.ref_err), 0);
    step(1);
    check("sat_err_set", int'(bus.ref_err), 1);
    check("sat_debt_hold", int'(bus.ref_debt), 8);
    bus.rw_idle = 1'b1;
    step(1);
    check("sat_ref_entry", int'(bus.ctrl_state), 5);
    check("sat_ref_cmd", int'(bus.ref_cmd), 1);
    step(10);
    check("sat_burst_next", int'(bus.ref_cmd), 1);
    check("sat_burst_debt", int'(bus.ref_debt), 7);
    check("err_sticky", int'(bus.ref_err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
